msx_mouse_port: RTL and testbench

Converts host mouse movement reports into the MSX mouse protocol on joystick port A. Sits between the MiST I/O controller (mouse_x/mouse_y/mouse_flags/mouse_strobe) and the joystick-port open-drain mapping feeding the MSX core. Movement is accumulated between MSX reads with saturation, and shifted out as four nibbles clocked by the MSX STROBE (pin 8) line. Mouse mode is entered automatically on mouse activity and left on joystick activity.

---
 rtl/msx_mouse_pkg.sv | 26 ++
 rtl/msx_mouse_axis.sv | 76 +++++++
 rtl/msx_mouse_port.sv | 132 +++++++++++++
 tb/tb_msx_mouse_port.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msx_mouse_pkg.sv
// Shared types, defaults and the 8-bit clamp used by the MSX mouse port.
package msx_mouse_pkg;

    // Order of nibbles shifted out on successive STROBE edges.
    typedef enum logic [1:0] {
        PH_XH = 2'd0,
        PH_XL = 2'd1,
        PH_YH = 2'd2,
        PH_YL = 2'd3
    } phase_e;

    localparam int TIMEOUT_DEF = 100000;
    localparam int ACC_W_DEF   = 11;

    // Clamp a sign-extended accumulator value to -128..+127.
    function automatic logic [7:0] sat8(input logic signed [31:0] v);
        if (v > 32'sd127) begin
            return 8'h7F;
        end else if (v < -32'sd128) begin
            return 8'h80;
        end else begin
            return v[7:0];
        end
    endfunction

endpackage

// File: rtl/msx_mouse_axis.sv
// One axis of mouse movement: saturating accumulator that adds host deltas
// and gives up an 8-bit clamped portion (keeping the residual) when read.
module msx_mouse_axis
    import msx_mouse_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter bit NEGATE = 1'b0
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              add_i,
    input  logic              latch_i,
    input  logic signed [8:0] delta_i,
    output logic [7:0]        sat_o,
    output logic [7:0]        lat_o
);

    // Headroom for acc + delta - latched before the final clamp.
    localparam int SW = ((ACC_W > 10) ? ACC_W : 10) + 2;
    localparam logic signed [SW-1:0] ACC_MAX = SW'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [SW-1:0] ACC_MIN = SW'(-(1 << (ACC_W - 1)));

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]              lat_q, lat_d;
    logic signed [SW-1:0]    step;
    logic signed [SW-1:0]    sum;

    assign sat_o = sat8(32'(acc_q));
    assign lat_o = lat_q;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        acc_d = acc_q;
        lat_d = lat_q;
        step  = SW'(delta_i);
        if (NEGATE) begin
            step = -step;
        end
        sum = SW'(acc_q);
        if (add_i) begin
            sum = sum + step;
        end
        if (latch_i) begin
            sum = sum - SW'($signed(sat_o));
        end

        if (clear_i) begin
            acc_d = '0;
            lat_d = '0;
        end else begin
            if (sum > ACC_MAX) begin
                acc_d = ACC_MAX[ACC_W-1:0];
            end else if (sum < ACC_MIN) begin
                acc_d = ACC_MIN[ACC_W-1:0];
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
            if (latch_i) begin
                lat_d = sat_o;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
        if (reset) begin
            acc_q <= '0;
            lat_q <= '0;
        end else begin
            acc_q <= acc_d;
            lat_q <= lat_d;
        end
    end

endmodule

// File: rtl/msx_mouse_port.sv
// MSX mouse protocol on joystick port A: accumulates host mouse reports and
// shifts them out as four nibbles clocked by either edge of the MSX STROBE line.
module msx_mouse_port
    import msx_mouse_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int ACC_W   = ACC_W_DEF
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic signed [8:0] mouse_x,
    input  logic signed [8:0] mouse_y,
    input  logic [7:0]        mouse_flags,
    input  logic              mouse_strobe,
    input  logic              joy_active,
    input  logic              stra,
    output logic              mouse_en,
    output logic [5:0]        port_out
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);

    // [0],[1] synchronise stra; [2] is the previous synchronised value.
    logic [2:0]    sync_q;
    logic          strobe_edge;
    logic          mouse_en_q, mouse_en_d;
    phase_e        phase_q, phase_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [5:0]    port_q, port_d;
    logic          latch;
    logic [7:0]    x_sat, y_sat, lx, ly;
    logic          unused_bits;

    assign strobe_edge = sync_q[2] ^ sync_q[1];
    assign mouse_en    = mouse_en_q;
    assign port_out    = port_q;
    assign unused_bits = ^{mouse_flags[7:2], lx[7:4], x_sat[3:0], y_sat};

    always_comb begin
        mouse_en_d = mouse_strobe ? 1'b1 : (joy_active ? 1'b0 : mouse_en_q);
        phase_d    = phase_q;
        tmo_d      = tmo_q;
        port_d     = port_q;
        latch      = 1'b0;

        if (!mouse_en_d) begin
            phase_d = PH_XH;
            tmo_d   = '0;
            port_d  = 6'h3F;
        end else begin
            if (mouse_strobe) begin
                port_d[5:4] = ~mouse_flags[1:0];
            end
            // An edge takes priority over the timeout expiring in the same cycle.
            if (strobe_edge) begin
                tmo_d = TMO_LOAD;
                case (phase_q)
                    PH_XH: begin
                        latch       = 1'b1;
                        port_d[3:0] = x_sat[7:4];
                        phase_d     = PH_XL;
                    end
                    PH_XL: begin
                        port_d[3:0] = lx[3:0];
                        phase_d     = PH_YH;
                    end
                    PH_YH: begin
                        port_d[3:0] = ly[7:4];
                        phase_d     = PH_YL;
                    end
                    PH_YL: begin
                        port_d[3:0] = ly[3:0];
                        phase_d     = PH_XH;
                    end
                    default: phase_d = PH_XH;
                endcase
            end else if (tmo_q != '0) begin
                tmo_d = tmo_q - 1'b1;
                if (tmo_q == TW'(1)) begin
                    phase_d = PH_XH;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            mouse_en_q <= 1'b0;
            phase_q    <= PH_XH;
            tmo_q      <= '0;
            port_q     <= 6'h3F;
        end else begin
            sync_q     <= {sync_q[1:0], stra};
            mouse_en_q <= mouse_en_d;
            phase_q    <= phase_d;
            tmo_q      <= tmo_d;
            port_q     <= port_d;
        end
    end

    // MSX X grows to the left, so the X axis negates host deltas.
    msx_mouse_axis #(
        .ACC_W  (ACC_W),
        .NEGATE (1'b1)
    ) u_axis_x (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clear_i (!mouse_en_d),
        .add_i   (mouse_strobe),
        .latch_i (latch),
        .delta_i (mouse_x),
        .sat_o   (x_sat),
        .lat_o   (lx)
    );

    msx_mouse_axis #(
        .ACC_W  (ACC_W),
        .NEGATE (1'b0)
    ) u_axis_y (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clear_i (!mouse_en_d),
        .add_i   (mouse_strobe),
        .latch_i (latch),
        .delta_i (mouse_y),
        .sat_o   (y_sat),
        .lat_o   (ly)
    );

endmodule

// File: tb/tb_msx_mouse_port.sv
// Bench for msx_mouse_port: directed scenarios plus randomized traffic, all
// compared against a cycle-level arithmetic model of the mouse protocol.
module tb_msx_mouse_port;

    localparam int TMO     = 40;
    localparam int ACC_MAX = 1023;
    localparam int ACC_MIN = -1024;

    logic              clk_sys      = 1'b0;
    logic              reset        = 1'b1;
    logic signed [8:0] mouse_x      = '0;
    logic signed [8:0] mouse_y      = '0;
    logic [7:0]        mouse_flags  = '0;
    logic              mouse_strobe = 1'b0;
    logic              joy_active   = 1'b0;
    logic              stra         = 1'b0;
    logic              mouse_en;
    logic [5:0]        port_out;

    int n_checks = 0;
    int n_errors = 0;

    msx_mouse_port #(
        .TIMEOUT (TMO),
        .ACC_W   (11)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .mouse_x      (mouse_x),
        .mouse_y      (mouse_y),
        .mouse_flags  (mouse_flags),
        .mouse_strobe (mouse_strobe),
        .joy_active   (joy_active),
        .stra         (stra),
        .mouse_en     (mouse_en),
        .port_out     (port_out)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         en;
        int         port;
        int         phase;
        int         tmo;
        int         ax;
        int         ay;
        int         lx;
        int         ly;
        logic [2:0] hist;   // stra samples: [0] newest
    } model_t;

    function automatic int clamp_acc(input int v);
        if (v > ACC_MAX) return ACC_MAX;
        if (v < ACC_MIN) return ACC_MIN;
        return v;
    endfunction

    function automatic int clamp8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic model_t reset_state();
        model_t r;
        r.en = 0; r.port = 'h3F; r.phase = 0; r.tmo = 0;
        r.ax = 0; r.ay = 0; r.lx = 0; r.ly = 0; r.hist = '0;
        return r;
    endfunction

    function automatic model_t next_state(input model_t s, input logic stb, input logic joy,
                                          input logic st, input int dx, input int dy, input int fl);
        model_t n;
        int     subx, suby, nib;
        logic   seen_edge;
        n         = s;
        subx      = 0;
        suby      = 0;
        nib       = 0;
        seen_edge = (s.hist[1] != s.hist[2]);
        n.hist    = {s.hist[1:0], st};
        n.en      = stb ? 1 : (joy ? 0 : s.en);
        if (n.en == 0) begin
            n.phase = 0; n.tmo = 0; n.ax = 0; n.ay = 0; n.port = 'h3F;
            return n;
        end
        if (seen_edge) begin
            if (s.phase == 0) begin
                n.lx = clamp8(s.ax);
                n.ly = clamp8(s.ay);
                subx = n.lx;
                suby = n.ly;
            end
            case (s.phase)
                0: nib = (n.lx & 255) / 16;
                1: nib = n.lx & 15;
                2: nib = (n.ly & 255) / 16;
                default: nib = n.ly & 15;
            endcase
            n.port  = (n.port & 'h30) | nib;
            n.phase = (s.phase + 1) % 4;
            n.tmo   = TMO;
        end else if (s.tmo > 0) begin
            n.tmo = s.tmo - 1;
            if (n.tmo == 0) n.phase = 0;
        end
        n.ax = clamp_acc(s.ax - (stb ? dx : 0) - subx);
        n.ay = clamp_acc(s.ay + (stb ? dy : 0) - suby);
        if (stb) n.port = (n.port & 'h0F) | (((~fl) & 3) * 16);
        return n;
    endfunction

    model_t m = reset_state();

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            m <= reset_state();
        end else begin
            m <= next_state(m, mouse_strobe, joy_active, stra,
                            int'(mouse_x), int'(mouse_y), int'(mouse_flags));
        end
    end

    always @(negedge clk_sys) begin
        check("cyc_mouse_en", 32'(mouse_en), 32'(m.en));
        check("cyc_port_out", 32'(port_out), 32'(m.port));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send(input int dx, input int dy, input logic [7:0] fl);
        mouse_x      = 9'(dx);
        mouse_y      = 9'(dy);
        mouse_flags  = fl;
        mouse_strobe = 1'b1;
        cycles(1);
        mouse_strobe = 1'b0;
    endtask

    task automatic read_nib(input string tag, input int exp);
        stra = ~stra;
        cycles(3);
        check(tag, 32'(port_out[3:0]), 32'(exp));
    endtask

    initial begin
        cycles(3);
        check("rst_port", 32'(port_out), 32'h3F);
        check("rst_en", 32'(mouse_en), 32'd0);
        reset = 1'b0;
        cycles(2);

        // Basic report: lx = -5 (FB), ly = +3 (03)
        send(5, 3, 8'h01);
        check("t1_en", 32'(mouse_en), 32'd1);
        check("t1_btn", 32'(port_out[5:4]), 32'b10);
        read_nib("t1_n0", 'hF);
        read_nib("t1_n1", 'hB);
        read_nib("t1_n2", 'h0);
        read_nib("t1_n3", 'h3);

        // Saturated read with residual: +300 -> 7F, 7F, 2E
        repeat (3) send(-100, 0, 8'h00);
        check("t2_btn", 32'(port_out[5:4]), 32'b11);
        for (int r = 0; r < 3; r++) begin
            read_nib("t2_xh", (r < 2) ? 'h7 : 'h2);
            read_nib("t2_xl", (r < 2) ? 'hF : 'hE);
            read_nib("t2_yh", 'h0);
            read_nib("t2_yl", 'h0);
        end

        // Strobe coincident with the phase-0 latch
        send(0, 1, 8'h00);
        stra = ~stra;
        cycles(2);
        mouse_x = '0; mouse_y = 9'sd2; mouse_strobe = 1'b1;
        cycles(1);
        mouse_strobe = 1'b0;
        check("t3_xh", 32'(port_out[3:0]), 32'h0);
        read_nib("t3_xl", 'h0);
        read_nib("t3_yh", 'h0);
        read_nib("t3_yl", 'h1);
        read_nib("t3b_xh", 'h0);
        read_nib("t3b_xl", 'h0);
        read_nib("t3b_yh", 'h0);
        read_nib("t3b_yl", 'h2);

        // Timeout returns the phase to 0 mid-sequence
        send(-'h35, 'h12, 8'h00);
        read_nib("t4_xh", 'h3);
        read_nib("t4_xl", 'h5);
        cycles(TMO + 5);
        check("t4_hold", 32'(port_out[3:0]), 32'h5);
        send(-'h4A, 0, 8'h00);
        read_nib("t4_tmo_xh", 'h4);
        read_nib("t4_tmo_xl", 'hA);
        read_nib("t4_tmo_yh", 'h0);
        read_nib("t4_tmo_yl", 'h0);

        // Joystick activity leaves mouse mode and clears accumulators
        send(-7, 0, 8'h00);
        joy_active = 1'b1;
        cycles(1);
        joy_active = 1'b0;
        check("t5_en_off", 32'(mouse_en), 32'd0);
        check("t5_port_off", 32'(port_out), 32'h3F);
        send(0, 0, 8'h00);
        check("t5_en_on", 32'(mouse_en), 32'd1);
        read_nib("t5_xh", 'h0);
        read_nib("t5_xl", 'h0);
        read_nib("t5_yh", 'h0);
        read_nib("t5_yl", 'h0);
        joy_active = 1'b1;
        send(0, 0, 8'h02);
        joy_active = 1'b0;
        check("t5_both_en", 32'(mouse_en), 32'd1);
        check("t5_both_port", 32'(port_out), 32'h10);

        // Reset in phase 2, then restart from phase 0
        send(-'h21, 'h13, 8'h00);
        read_nib("t6_xh", 'h2);
        read_nib("t6_xl", 'h1);
        reset = 1'b1;
        #1;
        check("t6_rst_port", 32'(port_out), 32'h3F);
        check("t6_rst_en", 32'(mouse_en), 32'd0);
        cycles(2);
        reset = 1'b0;
        send(-'h56, 0, 8'h00);
        read_nib("t6_xh2", 'h5);
        read_nib("t6_xl2", 'h6);
        read_nib("t6_yh2", 'h0);
        read_nib("t6_yl2", 'h0);

        // Randomized traffic: busy, slow and idle STROBE periods
        for (int blk = 0; blk < 24; blk++) begin
            int tdiv;
            tdiv = (blk % 3 == 0) ? 2 : ((blk % 3 == 1) ? 8 : 0);
            for (int c = 0; c < 100; c++) begin
                mouse_strobe = ($urandom_range(3) == 0);
                mouse_x      = 9'($urandom);
                mouse_y      = 9'($urandom);
                mouse_flags  = 8'($urandom);
                joy_active   = ($urandom_range(59) == 0);
                if (tdiv != 0 && $urandom_range(tdiv - 1) == 0) stra = ~stra;
                reset        = ($urandom_range(399) == 0);
                cycles(1);
            end
        end
        mouse_strobe = 1'b0;
        joy_active   = 1'b0;
        reset        = 1'b0;
        cycles(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
